// File: rtl/pipe_pc_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipe_pc_ctrl_if
// Bundle of the request/response signals between the IF-stage front end and
// the program-counter controller. Names are taken from the controller's point
// of view: i_* flow into the controller, o_* flow out of it.
//
// Parameters:
//   WIDTH        PC / target width in bits
// Signals:
//   i_stall      hold the PC this cycle
//   i_exc        exception redirect request
//   i_br_taken   EX branch redirect request, target on i_br_target
//   i_jmp        ID jump redirect request, target on i_jmp_target
//   i_call       push return address (return-address stack builds only)
//   i_ret        pop-and-redirect (return-address stack builds only)
//   o_pc         current fetch PC
//   o_pc_valid   o_pc is a legitimate fetch address
//   o_flush      one-cycle pulse after a non-sequential PC load
//   o_ras_err    one-cycle pulse after a ret on an empty stack
// Modports:
//   master       request side (front end / testbench)
//   slave        the controller
// -----------------------------------------------------------------------------
interface pipe_pc_ctrl_if #(
    parameter int unsigned WIDTH = 32
);
    logic             i_stall;
    logic             i_exc;
    logic             i_br_taken;
    logic [WIDTH-1:0] i_br_target;
    logic             i_jmp;
    logic [WIDTH-1:0] i_jmp_target;
    logic             i_call;
    logic             i_ret;
    logic [WIDTH-1:0] o_pc;
    logic             o_pc_valid;
    logic             o_flush;
    logic             o_ras_err;

    modport master (
        output i_stall, i_exc, i_br_taken, i_br_target, i_jmp, i_jmp_target,
               i_call, i_ret,
        input  o_pc, o_pc_valid, o_flush, o_ras_err
    );

    modport slave (
        input  i_stall, i_exc, i_br_taken, i_br_target, i_jmp, i_jmp_target,
               i_call, i_ret,
        output o_pc, o_pc_valid, o_flush, o_ras_err
    );
endinterface

// File: rtl/pipe_pc_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_pc_ctrl
// Fetch program-counter controller for the IF stage. Holds the fetch PC,
// advances it by INC, and applies prioritised redirects
// (exception > branch > jump > return). Redirects seen while stalled are held
// in a single pending slot and applied on the first unstalled edge.
//
// Optional feature: define PIPEPC_RAS_EN to build a RAS_DEPTH-entry circular
// return-address stack driven by call/ret. Without it call/ret are ignored
// and o_ras_err is constant 0.
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   pipe_pc_ctrl_if.slave (requests in, registered PC/status out)
// -----------------------------------------------------------------------------
module pipe_pc_ctrl #(
    parameter int unsigned      WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VEC = '0,
    parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(32'h0000_0008),
    parameter int unsigned      INC       = 4,
    parameter int unsigned      RAS_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    pipe_pc_ctrl_if.slave bus
);
    typedef enum logic [1:0] {S_BOOT, S_RUN, S_PEND} state_t;

    // Redirect priorities; 0 means "no redirect".
    localparam logic [1:0] P_NONE = 2'd0;
    localparam logic [1:0] P_JMP  = 2'd1;
    localparam logic [1:0] P_BR   = 2'd2;
    localparam logic [1:0] P_EXC  = 2'd3;

    state_t           r_state, w_state_next;
    logic [WIDTH-1:0] r_pc, w_pc_next;
    logic             r_pc_valid, w_pc_valid_next;
    logic             r_flush, w_flush_next;
    logic             r_ras_err, w_ras_err_next;
    logic [1:0]       r_pend_prio, w_pend_prio_next;
    logic [WIDTH-1:0] r_pend_tgt, w_pend_tgt_next;

    logic [1:0]       w_live_prio;
    logic [WIDTH-1:0] w_live_tgt;
    logic [WIDTH-1:0] w_seq_pc;
    logic             w_call, w_ret;
    logic             w_push, w_pop;
    logic             w_ras_nonempty;
    logic [WIDTH-1:0] w_ras_top_val;

    assign w_seq_pc = r_pc + WIDTH'(INC);

    // Highest-priority bufferable request this cycle (ret is not bufferable).
    always_comb begin
        w_live_prio = P_NONE;
        w_live_tgt  = '0;
        if (bus.i_exc) begin
            w_live_prio = P_EXC;
            w_live_tgt  = EXC_VEC;
        end else if (bus.i_br_taken) begin
            w_live_prio = P_BR;
            w_live_tgt  = bus.i_br_target;
        end else if (bus.i_jmp) begin
            w_live_prio = P_JMP;
            w_live_tgt  = bus.i_jmp_target;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_BOOT;
            r_pc        <= RESET_VEC;
            r_pc_valid  <= 1'b0;
            r_flush     <= 1'b0;
            r_ras_err   <= 1'b0;
            r_pend_prio <= P_NONE;
            r_pend_tgt  <= '0;
        end else begin
            r_state     <= w_state_next;
            r_pc        <= w_pc_next;
            r_pc_valid  <= w_pc_valid_next;
            r_flush     <= w_flush_next;
            r_ras_err   <= w_ras_err_next;
            r_pend_prio <= w_pend_prio_next;
            r_pend_tgt  <= w_pend_tgt_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_pc_next        = r_pc;
        w_pc_valid_next  = r_pc_valid;
        w_flush_next     = 1'b0;
        w_ras_err_next   = 1'b0;
        w_pend_prio_next = r_pend_prio;
        w_pend_tgt_next  = r_pend_tgt;
        w_push           = 1'b0;
        w_pop            = 1'b0;
        case (r_state)
            S_BOOT: begin
                // Requests and stall are deliberately ignored here.
                w_state_next    = S_RUN;
                w_pc_valid_next = 1'b1;
            end
            S_RUN: begin
                if (bus.i_stall) begin
                    if (w_live_prio != P_NONE) begin
                        w_pend_prio_next = w_live_prio;
                        w_pend_tgt_next  = w_live_tgt;
                        w_state_next     = S_PEND;
                    end
                end else begin
                    w_push = w_call;
                    if (w_live_prio != P_NONE) begin
                        w_pc_next    = w_live_tgt;
                        w_flush_next = 1'b1;
                    end else if (w_ret && w_ras_nonempty) begin
                        w_pc_next    = w_ras_top_val;
                        w_flush_next = 1'b1;
                        w_pop        = 1'b1;
                    end else begin
                        w_pc_next      = w_seq_pc;
                        w_ras_err_next = w_ret;
                    end
                end
            end
            S_PEND: begin
                if (bus.i_stall) begin
                    // >= lets an equal-priority request refresh the target
                    // while keeping exc sticky against br/jmp.
                    if (w_live_prio != P_NONE && w_live_prio >= r_pend_prio) begin
                        w_pend_prio_next = w_live_prio;
                        w_pend_tgt_next  = w_live_tgt;
                    end
                end else begin
                    // Pending always outranks ret, so no pop can occur here.
                    w_push = w_call;
                    if (w_live_prio != P_NONE && w_live_prio >= r_pend_prio)
                        w_pc_next = w_live_tgt;
                    else
                        w_pc_next = r_pend_tgt;
                    w_flush_next     = 1'b1;
                    w_pend_prio_next = P_NONE;
                    w_state_next     = S_RUN;
                end
            end
            default: begin
                w_state_next = S_BOOT;
            end
        endcase
    end

`ifdef PIPEPC_RAS_EN
    localparam int unsigned RAS_AW = $clog2(RAS_DEPTH);

    logic [WIDTH-1:0]  r_ras_mem [RAS_DEPTH];
    logic [RAS_AW-1:0] r_ras_top;
    logic [RAS_AW:0]   r_ras_cnt;

    assign w_call         = bus.i_call;
    assign w_ret          = bus.i_ret;
    assign w_ras_nonempty = (r_ras_cnt != '0);
    assign w_ras_top_val  = r_ras_mem[r_ras_top];

    // Pointer/count: full pushes wrap over the oldest entry and the count
    // saturates; pop+push leaves the pointer alone and rewrites the top.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ras_top <= '0;
            r_ras_cnt <= '0;
        end else if (w_pop && !w_push) begin
            r_ras_top <= r_ras_top - 1'b1;
            r_ras_cnt <= r_ras_cnt - 1'b1;
        end else if (w_push && !w_pop) begin
            r_ras_top <= r_ras_top + 1'b1;
            if (r_ras_cnt != (RAS_AW+1)'(RAS_DEPTH))
                r_ras_cnt <= r_ras_cnt + 1'b1;
        end
    end

    // Stack storage has no reset; the count alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (w_push && w_pop)
            r_ras_mem[r_ras_top] <= w_seq_pc;
        else if (w_push)
            r_ras_mem[r_ras_top + 1'b1] <= w_seq_pc;
    end

    assign bus.o_ras_err = r_ras_err;
`else
    assign w_call         = 1'b0;
    assign w_ret          = 1'b0;
    assign w_ras_nonempty = 1'b0;
    assign w_ras_top_val  = '0;
    assign bus.o_ras_err  = 1'b0;

    wire w_unused_ras = ^{bus.i_call, bus.i_ret, w_push, w_pop, r_ras_err,
                          32'(RAS_DEPTH)};
`endif

    assign bus.o_pc       = r_pc;
    assign bus.o_pc_valid = r_pc_valid;
    assign bus.o_flush    = r_flush;
endmodule

// File: tb/tb_pipe_pc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_pc_ctrl
// Directed bench for pipe_pc_ctrl: a 32-bit instance for reset/boot, priority,
// stall buffering, the optional return-address stack and reset mid-stall,
// plus an 8-bit instance for PC wrap-around.
// -----------------------------------------------------------------------------
module tb_pipe_pc_ctrl;
    logic clk = 1'b0;
    logic rst;
    logic rst8;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pipe_pc_ctrl_if #(.WIDTH(32)) u_if ();
    pipe_pc_ctrl_if #(.WIDTH(8))  u_if8 ();

    pipe_pc_ctrl #(
        .WIDTH(32), .RESET_VEC(32'h0), .EXC_VEC(32'h0000_0008),
        .INC(4), .RAS_DEPTH(4)
    ) u_dut (
        .clk(clk), .rst(rst), .bus(u_if)
    );

    pipe_pc_ctrl #(
        .WIDTH(8), .RESET_VEC(8'h00), .EXC_VEC(8'h08),
        .INC(4), .RAS_DEPTH(4)
    ) u_dut8 (
        .clk(clk), .rst(rst8), .bus(u_if8)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        u_if.i_stall      = 1'b0;
        u_if.i_exc        = 1'b0;
        u_if.i_br_taken   = 1'b0;
        u_if.i_br_target  = '0;
        u_if.i_jmp        = 1'b0;
        u_if.i_jmp_target = '0;
        u_if.i_call       = 1'b0;
        u_if.i_ret        = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %-14s observed %0h expected %0h", tag, obs, exp);
    endtask

    // pc, pc_valid, flush in one call
    task automatic chk3(input string tag, input logic [31:0] pc, input logic v, input logic f);
        chk({tag, ".pc"}, u_if.o_pc, pc);
        chk({tag, ".valid"}, 32'(u_if.o_pc_valid), 32'(v));
        chk({tag, ".flush"}, 32'(u_if.o_flush), 32'(f));
    endtask

    initial begin
        rst  = 1'b1;
        rst8 = 1'b1;
        clr();
        u_if8.i_stall = 1'b0; u_if8.i_exc = 1'b0; u_if8.i_br_taken = 1'b0;
        u_if8.i_br_target = '0; u_if8.i_jmp = 1'b0; u_if8.i_jmp_target = '0;
        u_if8.i_call = 1'b0; u_if8.i_ret = 1'b0;

        // Reset held for three cycles
        tick();
        chk3("rst", 32'h0, 1'b0, 1'b0);
        chk("rst.ras_err", 32'(u_if.o_ras_err), 32'h0);
        tick();
        tick();
        rst = 1'b0;
        chk3("boot", 32'h0, 1'b0, 1'b0);
        tick(); chk3("run0", 32'h0, 1'b1, 1'b0);
        tick(); chk3("seq4", 32'h4, 1'b1, 1'b0);
        tick(); chk3("seq8", 32'h8, 1'b1, 1'b0);
        tick(); chk3("seqC", 32'hC, 1'b1, 1'b0);
        tick(); chk3("seq10", 32'h10, 1'b1, 1'b0);

        // All three redirects at once: exception wins
        u_if.i_exc = 1'b1;
        u_if.i_br_taken = 1'b1; u_if.i_br_target = 32'h100;
        u_if.i_jmp = 1'b1;      u_if.i_jmp_target = 32'h200;
        tick(); chk3("prio", 32'h8, 1'b1, 1'b1);
        clr();
        tick(); chk3("prio.after", 32'hC, 1'b1, 1'b0);

        // Stall buffering: jmp then br, br replaces jmp
        u_if.i_jmp = 1'b1; u_if.i_jmp_target = 32'h20;
        tick(); chk3("to20", 32'h20, 1'b1, 1'b1);
        clr(); u_if.i_stall = 1'b1; u_if.i_jmp = 1'b1; u_if.i_jmp_target = 32'h300;
        tick(); chk3("stl1", 32'h20, 1'b1, 1'b0);
        clr(); u_if.i_stall = 1'b1; u_if.i_br_taken = 1'b1; u_if.i_br_target = 32'h400;
        tick(); chk3("stl2", 32'h20, 1'b1, 1'b0);
        clr(); u_if.i_stall = 1'b1;
        tick(); chk3("stl3", 32'h20, 1'b1, 1'b0);
        clr();
        tick(); chk3("stl.rel", 32'h400, 1'b1, 1'b1);
        tick(); chk3("stl.seq", 32'h404, 1'b1, 1'b0);

        // Exception stays sticky against a later branch
        u_if.i_stall = 1'b1; u_if.i_exc = 1'b1;
        tick(); chk("exc1.pc", u_if.o_pc, 32'h404);
        clr(); u_if.i_stall = 1'b1; u_if.i_br_taken = 1'b1; u_if.i_br_target = 32'h600;
        tick(); chk("exc2.pc", u_if.o_pc, 32'h404);
        clr();
        tick(); chk3("exc.rel", 32'h8, 1'b1, 1'b1);

        // Release with a lower-priority live request: pending br wins
        u_if.i_stall = 1'b1; u_if.i_br_taken = 1'b1; u_if.i_br_target = 32'h700;
        tick(); chk("lo.hold", u_if.o_pc, 32'h8);
        clr(); u_if.i_jmp = 1'b1; u_if.i_jmp_target = 32'h800;
        tick(); chk3("lo.rel", 32'h700, 1'b1, 1'b1);

        // Release with an equal-priority live request: live wins
        clr(); u_if.i_stall = 1'b1; u_if.i_jmp = 1'b1; u_if.i_jmp_target = 32'h900;
        tick(); chk("tie.hold", u_if.o_pc, 32'h700);
        clr(); u_if.i_jmp = 1'b1; u_if.i_jmp_target = 32'hA00;
        tick(); chk3("tie.rel", 32'hA00, 1'b1, 1'b1);

        // Stall without a request just holds
        clr(); u_if.i_stall = 1'b1;
        tick(); chk3("idle.stl", 32'hA00, 1'b1, 1'b0);
        clr();
        tick(); chk3("idle.rel", 32'hA04, 1'b1, 1'b0);

`ifdef PIPEPC_RAS_EN
        // Five calls into a 4-deep stack, then five returns
        u_if.i_jmp = 1'b1; u_if.i_jmp_target = 32'h10;
        tick(); chk("ras.to10", u_if.o_pc, 32'h10);
        for (int i = 1; i <= 5; i++) begin
            clr(); u_if.i_call = 1'b1; u_if.i_jmp = 1'b1;
            u_if.i_jmp_target = 32'((i + 1) * 16);
            tick(); chk("ras.call", u_if.o_pc, 32'((i + 1) * 16));
        end
        clr(); u_if.i_ret = 1'b1;
        tick(); chk3("ret1", 32'h54, 1'b1, 1'b1);
        tick(); chk3("ret2", 32'h44, 1'b1, 1'b1);
        tick(); chk3("ret3", 32'h34, 1'b1, 1'b1);
        tick(); chk3("ret4", 32'h24, 1'b1, 1'b1);
        chk("ret4.err", 32'(u_if.o_ras_err), 32'h0);
        tick(); chk3("ret5", 32'h28, 1'b1, 1'b0);
        chk("ret5.err", 32'(u_if.o_ras_err), 32'h1);
        clr();
        tick(); chk("ret.after", u_if.o_pc, 32'h2C);
        chk("ret.aft.err", 32'(u_if.o_ras_err), 32'h0);
`else
        // call/ret have no effect without the stack
        u_if.i_call = 1'b1; u_if.i_ret = 1'b1;
        tick(); chk3("noras", 32'hA08, 1'b1, 1'b0);
        chk("noras.err", 32'(u_if.o_ras_err), 32'h0);
        clr();
`endif

        // Reset in the middle of a stall with a pending branch
        clr(); u_if.i_jmp = 1'b1; u_if.i_jmp_target = 32'h40;
        tick(); chk("mid.to40", u_if.o_pc, 32'h40);
        clr(); u_if.i_stall = 1'b1; u_if.i_br_taken = 1'b1; u_if.i_br_target = 32'h500;
        tick(); chk("mid.hold", u_if.o_pc, 32'h40);
        #2;
        rst = 1'b1;
        #1;
        chk3("mid.rst", 32'h0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        clr();
        chk3("mid.boot", 32'h0, 1'b0, 1'b0);
        tick(); chk3("mid.run", 32'h0, 1'b1, 1'b0);
        tick(); chk3("mid.seq4", 32'h4, 1'b1, 1'b0);
        tick(); chk3("mid.seq8", 32'h8, 1'b1, 1'b0);

        // 8-bit wrap-around
        rst8 = 1'b0;
        chk("w8.boot.v", 32'(u_if8.o_pc_valid), 32'h0);
        tick(); chk("w8.run.v", 32'(u_if8.o_pc_valid), 32'h1);
        u_if8.i_jmp = 1'b1; u_if8.i_jmp_target = 8'hF8;
        tick(); chk("w8.F8", 32'(u_if8.o_pc), 32'hF8);
        u_if8.i_jmp = 1'b0;
        tick(); chk("w8.FC", 32'(u_if8.o_pc), 32'hFC);
        chk("w8.FC.flush", 32'(u_if8.o_flush), 32'h0);
        tick(); chk("w8.00", 32'(u_if8.o_pc), 32'h00);
        chk("w8.00.flush", 32'(u_if8.o_flush), 32'h0);
        tick(); chk("w8.04", 32'(u_if8.o_pc), 32'h04);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
